tagged_pick_actor: RTL
======================

Name: tagged_pick_actor

Overview:
- Parametrised multi-flux PICK actor for the dataflow (DDF) fabric; successor to the fixed 1-port/2-flux PICK wrapper.
- Accepts tagged data tokens and tagged control (NDA) tokens, and buffers them in per-flux FIFOs.
- Fires one flux at a time under round-robin arbitration. Each firing consumes BLOCK data tokens plus one control token, and emits the data token the control token indexes, re-tagged with its flux.
- Sits between upstream tagged producers and a downstream FIFO that signals full.

Parameters:
- FLUX, 2, number of interleaved fluxes (>=2).
- DATA_WIDTH, 8, payload width.
- TAG_WIDTH, $clog2(FLUX), tag width; tag occupies the MSBs of every token.
- BLOCK, 4, data tokens consumed per firing (power of two, >=2).
- DEPTH, 8, per-flux data FIFO depth (power of two, >=BLOCK).
- CDEPTH, 2, per-flux control FIFO depth (power of two, >=1).

Ports:
- clk  in  1  clock; all logic is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_port_write  in  1  data token valid.
- in_port_datain  in  DATA_WIDTH+TAG_WIDTH  {tag, payload}.
- in_port_full  out  FLUX  per-flux data FIFO full.
- in_port_write_nda  in  1  control token valid.
- in_port_datain_nda  in  DATA_WIDTH+TAG_WIDTH  {tag, index payload}.
- in_port_full_nda  out  FLUX  per-flux control FIFO full.
- out_port_write  out  1  output token strobe.
- out_port_dataout  out  DATA_WIDTH+TAG_WIDTH  {flux tag, picked payload}.
- out_port_full  in  1  downstream full.
- drop_err  out  1  sticky flag: a token was discarded.

Behaviour:
- Reset (rst=1 at an edge):
  - All FIFOs are flushed.
  - FSM goes to IDLE and the round-robin pointer goes to 0.
  - out_port_write=0, out_port_dataout=0, drop_err=0.
  - in_port_full and in_port_full_nda are 0.
  - Reset asserted mid-firing abandons that firing; no output is produced.
- Input writes:
  - A write is accepted at the edge where in_port_write=1, the tag is < FLUX, and that flux's FIFO is not full.
  - A write to a full FIFO, or a write with tag >= FLUX, is discarded and sets drop_err. This holds even if the same FIFO pops in the same cycle.
  - Data and NDA ports are independent; both may write in the same cycle.
- Full flags: in_port_full[f] is registered and equals (count==DEPTH). in_port_full_nda[f] likewise equals (count==CDEPTH).
- Eligibility: flux f is eligible when data count >= BLOCK and control count >= 1. Counts are post-write register values.
- FSM states:
  - IDLE: if any flux is eligible, select the first eligible flux starting at rr_ptr and wrapping modulo FLUX.
    - Latch sel and the index idx = control payload[$clog2(BLOCK)-1:0]; upper payload bits are ignored.
    - Pop the control token and go to DRAIN with cnt=0.
  - DRAIN: pop one data token of sel per cycle. When cnt==idx, latch that payload. After BLOCK pops, go to EMIT.
  - EMIT: when out_port_full=0:
    - Assert out_port_write for exactly one cycle with out_port_dataout={sel tag, latched payload}.
    - Set rr_ptr=sel+1 (mod FLUX) and go to IDLE.
    - While out_port_full=1, hold in EMIT with out_port_write=0 and out_port_dataout stable.
- Latency: the firing decision is made in IDLE cycle t, pops occur at t+1..t+BLOCK, and out_port_write is asserted at cycle t+BLOCK+1 at the earliest.
- Throughput: one firing per BLOCK+2 cycles when downstream is never full.
- Pops and accepted writes may occur on the same FIFO in the same cycle; the count is unchanged.
- Data FIFO pointers wrap modulo DEPTH; control FIFO pointers wrap modulo CDEPTH.
- out_port_dataout holds its last value outside EMIT.

Test Plan:
- Single firing: FLUX=2, BLOCK=4. Flux1 data payloads 10,11,12,13, then NDA {1,8'd2} -> exactly one out_port_write with {1'b1,8'd12}, 6 cycles after the NDA token is accepted.
- Round robin: both fluxes hold 4 data tokens and 1 NDA token (index 0, data 0x20/0x30) before the first firing -> outputs in order {0,0x20}, then {1,0x30}. A second pair of NDA tokens with refilled data then starts at flux 0 again.
- Backpressure: hold out_port_full=1 during EMIT for 5 cycles -> out_port_write=0 and dataout stable; a single write occurs in the cycle after full drops. The upstream data FIFO fills to 8 and in_port_full[f]=1.
- Overflow: write 9 flux0 data tokens with no NDA -> in_port_full[0]=1 after 8, the 9th is dropped and drop_err=1. A subsequent firing with index 3 outputs the 4th token.
- Bad tag and index: FLUX=3 (TAG_WIDTH=2), write a token with tag 3 -> drop_err=1 and no FIFO count change. NDA payload 8'd6 with BLOCK=4 -> index 2 is used.
- Reset mid-DRAIN: assert rst for 1 cycle after 2 pops -> no output, all full flags 0, drop_err=0; a fresh firing afterwards is correct.

Source files
------------

// File: rtl/tagged_pick_actor.sv
// Multi-flux tagged PICK actor for the dataflow fabric.
// Buffers tagged data/control tokens per flux and emits the indexed token.
module tagged_pick_actor #(
    parameter int FLUX       = 2,
    parameter int DATA_WIDTH = 8,
    parameter int TAG_WIDTH  = $clog2(FLUX),
    parameter int BLOCK      = 4,
    parameter int DEPTH      = 8,
    parameter int CDEPTH     = 2
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            in_port_write,
    input  logic [DATA_WIDTH+TAG_WIDTH-1:0] in_port_datain,
    output logic [FLUX-1:0]                 in_port_full,
    input  logic                            in_port_write_nda,
    input  logic [DATA_WIDTH+TAG_WIDTH-1:0] in_port_datain_nda,
    output logic [FLUX-1:0]                 in_port_full_nda,
    output logic                            out_port_write,
    output logic [DATA_WIDTH+TAG_WIDTH-1:0] out_port_dataout,
    input  logic                            out_port_full,
    output logic                            drop_err
);

    localparam int W   = DATA_WIDTH + TAG_WIDTH;
    localparam int TW  = TAG_WIDTH;
    localparam int IW  = $clog2(BLOCK);
    localparam int DPW = $clog2(DEPTH);
    localparam int CPW = (CDEPTH > 1) ? $clog2(CDEPTH) : 1;
    localparam int DCW = $clog2(DEPTH + 1);
    localparam int CCW = $clog2(CDEPTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        DRAIN,
        EMIT
    } state_t;

    logic [TW-1:0]         dtag;
    logic [TW-1:0]         ctag;
    logic [DATA_WIDTH-1:0] dpay;
    logic [IW-1:0]         cpay;
    logic                  nda_unused;

    assign dtag       = in_port_datain[W-1:DATA_WIDTH];
    assign dpay       = in_port_datain[DATA_WIDTH-1:0];
    assign ctag       = in_port_datain_nda[W-1:DATA_WIDTH];
    assign cpay       = in_port_datain_nda[IW-1:0];
    assign nda_unused = ^in_port_datain_nda;

    logic [DATA_WIDTH-1:0] dmem_q [FLUX][DEPTH];
    logic [IW-1:0]         cmem_q [FLUX][CDEPTH];
    logic [DPW-1:0]        dwr_q  [FLUX];
    logic [DPW-1:0]        drd_q  [FLUX];
    logic [CPW-1:0]        cwr_q  [FLUX];
    logic [CPW-1:0]        crd_q  [FLUX];
    logic [DCW-1:0]        dcnt_q [FLUX];
    logic [DCW-1:0]        dcnt_d [FLUX];
    logic [CCW-1:0]        ccnt_q [FLUX];
    logic [CCW-1:0]        ccnt_d [FLUX];
    logic [FLUX-1:0]       dfull_q;
    logic [FLUX-1:0]       cfull_q;

    logic [FLUX-1:0] dpush;
    logic [FLUX-1:0] cpush;
    logic [FLUX-1:0] dpop;
    logic [FLUX-1:0] cpop;
    logic [FLUX-1:0] elig;
    logic            found;
    logic [TW-1:0]   pick;
    logic            drop_now;

    state_t          state_q;
    logic [TW-1:0]   rr_q;
    logic [TW-1:0]   sel_q;
    logic [IW-1:0]   idx_q;
    logic [IW-1:0]   cnt_q;
    logic [DATA_WIDTH-1:0] latch_q;
    logic            out_write_q;
    logic [W-1:0]    dout_q;
    logic            drop_q;

    function automatic logic [DPW-1:0] dinc(input logic [DPW-1:0] p);
        return (p == DPW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    function automatic logic [CPW-1:0] cinc(input logic [CPW-1:0] p);
        return (p == CPW'(CDEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Route writes and pops to the flux FIFOs, derive next counts.
    always_comb begin
        dpush    = '0;
        cpush    = '0;
        dpop     = '0;
        cpop     = '0;
        elig     = '0;
        for (int f = 0; f < FLUX; f++) begin
            dcnt_d[f] = dcnt_q[f];
            ccnt_d[f] = ccnt_q[f];
        end
        for (int f = 0; f < FLUX; f++) begin
            dpush[f] = in_port_write && (dtag == TW'(f)) && !dfull_q[f];
            cpush[f] = in_port_write_nda && (ctag == TW'(f)) && !cfull_q[f];
            dpop[f]  = (state_q == DRAIN) && (sel_q == TW'(f));
            cpop[f]  = (state_q == IDLE) && found && (pick == TW'(f));
            elig[f]  = (dcnt_q[f] >= DCW'(BLOCK)) && (ccnt_q[f] != '0);
            dcnt_d[f] = dcnt_q[f] + DCW'(dpush[f]) - DCW'(dpop[f]);
            ccnt_d[f] = ccnt_q[f] + CCW'(cpush[f]) - CCW'(cpop[f]);
        end
        drop_now = (in_port_write && (dpush == '0))
                 || (in_port_write_nda && (cpush == '0));
    end

    // Round-robin search: first eligible flux at or above rr, else wrap.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        for (int f = 0; f < FLUX; f++) begin
            if (!found && elig[f] && (TW'(f) >= rr_q)) begin
                found = 1'b1;
                pick  = TW'(f);
            end
        end
        for (int f = 0; f < FLUX; f++) begin
            if (!found && elig[f]) begin
                found = 1'b1;
                pick  = TW'(f);
            end
        end
    end

    // Per-flux data FIFOs with registered full flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int f = 0; f < FLUX; f++) begin
                dwr_q[f]  <= '0;
                drd_q[f]  <= '0;
                dcnt_q[f] <= '0;
            end
            dfull_q <= '0;
        end else begin
            for (int f = 0; f < FLUX; f++) begin
                if (dpush[f]) begin
                    dmem_q[f][dwr_q[f]] <= dpay;
                    dwr_q[f] <= dinc(dwr_q[f]);
                end
                if (dpop[f]) begin
                    drd_q[f] <= dinc(drd_q[f]);
                end
                dcnt_q[f]  <= dcnt_d[f];
                dfull_q[f] <= (dcnt_d[f] == DCW'(DEPTH));
            end
        end
    end

    // Per-flux control FIFOs holding only the index bits.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int f = 0; f < FLUX; f++) begin
                cwr_q[f]  <= '0;
                crd_q[f]  <= '0;
                ccnt_q[f] <= '0;
            end
            cfull_q <= '0;
        end else begin
            for (int f = 0; f < FLUX; f++) begin
                if (cpush[f]) begin
                    cmem_q[f][cwr_q[f]] <= cpay;
                    cwr_q[f] <= cinc(cwr_q[f]);
                end
                if (cpop[f]) begin
                    crd_q[f] <= cinc(crd_q[f]);
                end
                ccnt_q[f]  <= ccnt_d[f];
                cfull_q[f] <= (ccnt_d[f] == CCW'(CDEPTH));
            end
        end
    end

    // Firing sequencer: select, drain BLOCK tokens, emit the picked one.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            rr_q        <= '0;
            sel_q       <= '0;
            idx_q       <= '0;
            cnt_q       <= '0;
            latch_q     <= '0;
            out_write_q <= 1'b0;
            dout_q      <= '0;
            drop_q      <= 1'b0;
        end else begin
            drop_q      <= drop_q | drop_now;
            out_write_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (found) begin
                        sel_q   <= pick;
                        idx_q   <= cmem_q[pick][crd_q[pick]];
                        cnt_q   <= '0;
                        state_q <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (cnt_q == idx_q) begin
                        latch_q <= dmem_q[sel_q][drd_q[sel_q]];
                    end
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == IW'(BLOCK - 1)) begin
                        state_q <= EMIT;
                    end
                end
                EMIT: begin
                    if (!out_port_full) begin
                        out_write_q <= 1'b1;
                        dout_q      <= {sel_q, latch_q};
                        rr_q        <= (sel_q == TW'(FLUX - 1)) ? '0
                                     : sel_q + 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_port_full     = dfull_q;
    assign in_port_full_nda = cfull_q;
    assign out_port_write   = out_write_q;
    assign out_port_dataout = dout_q;
    assign drop_err         = drop_q;

endmodule
